// File: rtl/pad_bidir_ctrl.sv
// pad_bidir_ctrl: direction sequencer and receive synchronizer for a group of bidirectional pads.
// Define PAD_RX_FILTER_EN to build the per-bit glitch filter on the receive path.
module pad_bidir_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYC    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       cfg_ds,
  input  logic             cfg_sr,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             rx_en,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic [WIDTH-1:0] pad_a,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] pad_ie,
  output logic             pad_ds0,
  output logic             pad_ds1,
  output logic             pad_sr,
  input  logic [WIDTH-1:0] pad_y
);

  localparam int CNT_MAX = (TURN_CYC > SYNC_STAGES + FILT_CYC) ? TURN_CYC : SYNC_STAGES + FILT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
`ifdef PAD_RX_FILTER_EN
  localparam int WARM_CYC = SYNC_STAGES + FILT_CYC;
`else
  localparam int WARM_CYC = SYNC_STAGES;
`endif
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYC - 1);
  localparam logic [CW-1:0] WARM_LOAD = CW'(WARM_CYC - 1);

  typedef enum logic [2:0] {IDLE, TX, RX_WARM, RX, TURN} state_t;

  state_t           state;
  state_t           dest;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] rx_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= pad_y;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef PAD_RX_FILTER_EN
  localparam int FW = $clog2(FILT_CYC);

  logic [WIDTH-1:0] filt_q;
  logic [FW-1:0]    filt_cnt [WIDTH];

  // A bit flips only after FILT_CYC consecutive synced samples disagree with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= '0;
      for (int b = 0; b < WIDTH; b++) filt_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (sync_q[SYNC_STAGES-1][b] == filt_q[b]) begin
          filt_cnt[b] <= '0;
        end else if (filt_cnt[b] == FW'(FILT_CYC - 1)) begin
          filt_q[b]   <= sync_q[SYNC_STAGES-1][b];
          filt_cnt[b] <= '0;
        end else begin
          filt_cnt[b] <= filt_cnt[b] + FW'(1);
        end
      end
    end
  end

  assign rx_word = filt_q;
`else
  assign rx_word = sync_q[SYNC_STAGES-1];
`endif

  // Outputs are set on the transition edge so they always match the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      dest     <= IDLE;
      cnt      <= '0;
      pad_a    <= '0;
      pad_oe   <= '0;
      pad_ie   <= '0;
      pad_ds0  <= 1'b0;
      pad_ds1  <= 1'b0;
      pad_sr   <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      busy     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          pad_ds0 <= cfg_ds[0];
          pad_ds1 <= cfg_ds[1];
          pad_sr  <= cfg_sr;
          if (tx_valid) begin
            state    <= TX;
            pad_oe   <= '1;
            tx_ready <= 1'b1;
            busy     <= 1'b1;
          end else if (rx_en) begin
            state  <= RX_WARM;
            pad_ie <= '1;
            cnt    <= WARM_LOAD;
            busy   <= 1'b1;
          end
        end
        TX: begin
          if (tx_valid && tx_ready) begin
            pad_a <= tx_data;
          end else if (!tx_valid) begin
            state    <= TURN;
            dest     <= rx_en ? RX_WARM : IDLE;
            pad_oe   <= '0;
            tx_ready <= 1'b0;
            cnt      <= TURN_LOAD;
          end
        end
        RX_WARM: begin
          if (cnt == '0) begin
            state    <= RX;
            rx_valid <= 1'b1;
            rx_data  <= rx_word;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RX: begin
          if (tx_valid || !rx_en) begin
            state  <= TURN;
            dest   <= tx_valid ? TX : IDLE;
            pad_ie <= '0;
            cnt    <= TURN_LOAD;
          end else if (rx_word != rx_data) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_word;
          end
        end
        TURN: begin
          if (cnt == '0) begin
            state <= dest;
            case (dest)
              TX: begin
                pad_oe   <= '1;
                tx_ready <= 1'b1;
              end
              RX_WARM: begin
                pad_ie <= '1;
                cnt    <= WARM_LOAD;
              end
              default: busy <= 1'b0;
            endcase
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          pad_oe   <= '0;
          pad_ie   <= '0;
          tx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
